// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: register map offsets and bit positions shared by the motor PWM block.
package motor_pwm_pkg;
    localparam logic [7:0] CTRL_OFS     = 8'd0;
    localparam logic [7:0] PRESCALE_OFS = 8'd1;
    localparam logic [7:0] CH_BASE_OFS  = 8'd2;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_WDOG_BIT = 1;
    localparam int CTRL_FCLR_BIT = 7;
    localparam int CH_EN_BIT     = 0;
    localparam int CH_DIR_BIT    = 1;
    function automatic logic [7:0] duty_ofs(input int ch);
        return CH_BASE_OFS + 8'(2 * ch);
    endfunction
    function automatic logic [7:0] chctl_ofs(input int ch);
        return CH_BASE_OFS + 8'(2 * ch + 1);
    endfunction
endpackage

// File: rtl/motor_pwm_ctrl_if.sv
// motor_pwm_ctrl_if: KCPSM6 port bus between the processor (master) and a peripheral (slave).
interface motor_pwm_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] read_data;
    modport master (output port_id, out_port, write_strobe, input read_data);
    modport slave  (input port_id, out_port, write_strobe, output read_data);
endinterface

// File: rtl/motor_pwm_ctrl_channel.sv
// pwm_channel: one PWM output with shadowed duty, enable and direction.
module pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_duty_we,
    input  logic                i_ctl_we,
    input  logic [7:0]          i_wdata,
    input  logic [PWM_BITS-1:0] i_period_cnt,
    input  logic                i_wrap,
    input  logic                i_enable_all,
    input  logic                i_fault,
    input  logic                i_trip,
    output logic                o_pwm,
    output logic                o_dir,
    output logic                o_en,
    output logic [PWM_BITS-1:0] o_pending
);
    logic [PWM_BITS-1:0] r_pending, r_active;
    logic                r_en, r_dir, r_pwm;

    // active duty only changes at the period wrap so no period is ever cut short
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_active  <= '0;
            r_en      <= 1'b0;
            r_dir     <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_duty_we) r_pending <= i_wdata[PWM_BITS-1:0];
            if (i_wrap) r_active <= r_pending;
            if (i_trip) r_en <= 1'b0;
            else if (i_ctl_we) r_en <= i_wdata[CH_EN_BIT];
            if (i_ctl_we) r_dir <= i_wdata[CH_DIR_BIT];
            r_pwm <= i_enable_all & r_en & ~i_fault & (i_period_cnt < r_active);
        end
    end

    assign o_pwm     = r_pwm;
    assign o_dir     = r_dir;
    assign o_en      = r_en;
    assign o_pending = r_pending;
endmodule

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: KCPSM6 port-mapped multi-channel PWM motor drive with
// shared prescaler, period counter and communication watchdog.
module motor_pwm_ctrl
    import motor_pwm_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter int         PWM_BITS    = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h10,
    parameter int         WDOG_CYCLES = 10_000_000
)(
    input  logic               clk,
    input  logic               reset,
    motor_pwm_ctrl_if.slave    bus,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic [NUM_CH-1:0]  dir_out,
    output logic               fault
);
    localparam int                  WDW     = $clog2(WDOG_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] PER_MAX = PWM_BITS'(2 ** PWM_BITS - 2);
    localparam logic [WDW-1:0]      WD_TERM = WDW'(WDOG_CYCLES - 1);

    logic [7:0]          w_ofs, w_rd;
    logic                w_we, w_ctrl_we, w_pre_we, w_fclr, w_tick, w_wrap, w_term, w_trip;
    logic                r_en_all, r_wdog_en, r_fault;
    logic [7:0]          r_prescale, r_pre_cnt, r_rd;
    logic [PWM_BITS-1:0] r_per_cnt;
    logic [WDW-1:0]      r_wd_cnt;
    logic [NUM_CH-1:0]   w_ch_en;
    logic [PWM_BITS-1:0] w_pending [NUM_CH];

    assign w_ofs     = bus.port_id - BASE_ADDR;
    assign w_we      = bus.write_strobe & (w_ofs < 8'(2 + 2 * NUM_CH));
    assign w_ctrl_we = w_we & (w_ofs == CTRL_OFS);
    assign w_pre_we  = w_we & (w_ofs == PRESCALE_OFS);
    assign w_fclr    = w_ctrl_we & bus.out_port[CTRL_FCLR_BIT];
    assign w_tick    = r_pre_cnt == r_prescale;
    assign w_wrap    = w_tick & (r_per_cnt == PER_MAX);
    assign w_term    = r_wdog_en & (r_wd_cnt == WD_TERM);
    // an in-range write landing on terminal count counts as a kick, not a timeout
    assign w_trip    = w_term & ~w_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_all   <= 1'b0;
            r_wdog_en  <= 1'b0;
            r_fault    <= 1'b0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_per_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_rd       <= '0;
        end else begin
            if (w_ctrl_we) begin
                r_en_all  <= bus.out_port[CTRL_EN_BIT];
                r_wdog_en <= bus.out_port[CTRL_WDOG_BIT];
            end
            if (w_pre_we) r_prescale <= bus.out_port;
            r_pre_cnt <= (w_pre_we | w_tick) ? '0 : r_pre_cnt + 8'd1;
            if (w_tick) r_per_cnt <= w_wrap ? '0 : r_per_cnt + 1'b1;
            r_wd_cnt <= (w_we | ~r_wdog_en | w_term) ? '0 : r_wd_cnt + 1'b1;
            r_fault  <= w_fclr ? 1'b0 : (w_trip | r_fault);
            r_rd     <= w_rd;
        end
    end

    always_comb begin
        w_rd = 8'h00;
        if (w_ofs == CTRL_OFS) w_rd = {r_fault, 5'b0, r_wdog_en, r_en_all};
        if (w_ofs == PRESCALE_OFS) w_rd = r_prescale;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ofs == duty_ofs(i)) w_rd = 8'(w_pending[i]);
            if (w_ofs == chctl_ofs(i)) w_rd = {6'b0, dir_out[i], w_ch_en[i]};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_duty_we    (w_we & (w_ofs == duty_ofs(c))),
            .i_ctl_we     (w_we & (w_ofs == chctl_ofs(c))),
            .i_wdata      (bus.out_port),
            .i_period_cnt (r_per_cnt),
            .i_wrap       (w_wrap),
            .i_enable_all (r_en_all),
            .i_fault      (r_fault),
            .i_trip       (w_trip),
            .o_pwm        (pwm_out[c]),
            .o_dir        (dir_out[c]),
            .o_en         (w_ch_en[c]),
            .o_pending    (w_pending[c])
        );
    end

    assign fault         = r_fault;
    assign bus.read_data = r_rd;
endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: randomized register and PWM duty checks against a
// register-map / duty-ratio model, plus watchdog and async reset scenarios.
module tb_motor_pwm_ctrl;
    import motor_pwm_pkg::*;
    localparam int         NUM_CH = 2;
    localparam int         WDOG   = 100;
    localparam logic [7:0] BASE   = 8'h10;
    localparam int         NREG   = 2 + 2 * NUM_CH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_CH-1:0] pwm_out, dir_out;
    logic fault;
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_ctrl, m_prescale;
    logic [7:0] m_duty [NUM_CH];
    logic [1:0] m_chctl [NUM_CH];
    logic       m_fault;

    motor_pwm_ctrl_if bus();

    motor_pwm_ctrl #(
        .NUM_CH(NUM_CH), .PWM_BITS(8), .BASE_ADDR(BASE), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pwm_out(pwm_out), .dir_out(dir_out), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_prescale = 0; m_fault = 0;
        for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_chctl[i] = 0; end
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        logic [7:0] o = a - BASE;
        int idx = (int'(o) - 2) / 2;
        if (o == 0) return {m_fault, 5'b0, m_ctrl[1:0]};
        if (o == 1) return m_prescale;
        if (int'(o) < NREG) return o[0] ? {6'b0, m_chctl[idx]} : m_duty[idx];
        return 8'h00;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] o = a - BASE;
        int idx = (int'(o) - 2) / 2;
        bus.port_id = a; bus.out_port = d; bus.write_strobe = 1'b1;
        @(posedge clk); #1;
        bus.write_strobe = 1'b0;
        if (o == 0) begin m_ctrl = d & 8'h03; if (d[7]) m_fault = 1'b0; end
        else if (o == 1) m_prescale = d;
        else if (int'(o) < NREG) begin
            if (o[0]) m_chctl[idx] = d[1:0];
            else m_duty[idx] = d;
        end
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a);
        bus.port_id = a;
        @(posedge clk); #1;
        check(tag, bus.read_data, exp_rd(a));
    endtask

    task automatic count_high(input int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        repeat (n) begin
            @(posedge clk); #1;
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
        end
    endtask

    // in steady state any window of one full period holds exactly duty*(PRESCALE+1) high cycles
    task automatic duty_run(input string tag, input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
        int c0, c1, per;
        logic dr0 = 1'($urandom);
        logic dr1 = 1'($urandom);
        per = 255 * (int'(p) + 1);
        wr(BASE, 8'h01);
        wr(BASE + 3, {6'b0, dr0, 1'b1});
        wr(BASE + 5, {6'b0, dr1, 1'b1});
        wr(BASE + 1, p);
        wr(BASE + 2, d0);
        wr(BASE + 4, d1);
        check({tag, "_dir"}, dir_out, {m_chctl[1][1], m_chctl[0][1]});
        repeat (2 * per + 4) @(posedge clk);
        count_high(per, c0, c1);
        check({tag, "_ch0"}, c0, int'(d0) * (int'(p) + 1));
        check({tag, "_ch1"}, c1, int'(d1) * (int'(p) + 1));
    endtask

    task automatic wait_rise(input string tag);
        logic prev = pwm_out[0];
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (!prev && pwm_out[0]) return;
            prev = pwm_out[0];
        end
        check({tag, "_rise_timeout"}, 0, 1);
    endtask

    task automatic run_len(output int run);
        run = 1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (!pwm_out[0]) return;
            run++;
        end
    endtask

    task automatic edges_to_fault(output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (fault) begin n = k; return; end
        end
    endtask

    initial begin
        int run, n, c0, c1;
        logic [7:0] a, d;
        bus.port_id = 0; bus.out_port = 0; bus.write_strobe = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", pwm_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_fault", fault, 0);
        check("rst_rd", bus.read_data, 0);
        reset = 1'b0;
        for (int i = -1; i <= NREG; i++) rd_check("rst_reg", BASE + 8'(i));

        for (int k = 0; k < 30; k++) begin
            a = ($urandom % 4 == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, NREG));
            d = 8'($urandom);
            if (a == BASE) d[1] = 1'b0;
            wr(a, d);
            rd_check("rand_reg", BASE + 8'($urandom_range(0, NREG)));
        end

        duty_run("sw0", 0, 0, 255);
        duty_run("sw1", 0, 64, 254);
        duty_run("sw2", 0, 254, 8'($urandom));
        duty_run("sw3", 0, 255, 1);
        duty_run("ps3", 3, 10, 8'($urandom));
        duty_run("psr", 8'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));

        wr(BASE + 1, 0);
        wr(BASE + 2, 100);
        repeat (600) @(posedge clk);
        wait_rise("shadow");
        run = 1;
        for (int j = 1; j < 300; j++) begin
            if (j == 50) begin bus.port_id = BASE + 2; bus.out_port = 200; bus.write_strobe = 1'b1; end
            @(posedge clk); #1;
            bus.write_strobe = 1'b0;
            if (!pwm_out[0]) break;
            run++;
        end
        m_duty[0] = 200;
        check("shadow_old", run, 100);
        wait_rise("shadow_new");
        run_len(run);
        check("shadow_new", run, 200);

        wr(BASE + 2, 255);
        wr(BASE + 3, 8'h01);
        repeat (600) @(posedge clk);
        #1;
        wr(BASE, 8'h03);
        edges_to_fault(n);
        check("wd_trip_cycle", n, WDOG);
        check("wd_pwm_last", pwm_out[0], 1);
        @(posedge clk); #1;
        check("wd_pwm_off", pwm_out[0], 0);
        m_fault = 1'b1;
        for (int i = 0; i < NUM_CH; i++) m_chctl[i][0] = 1'b0;
        rd_check("wd_ctrl", BASE);
        rd_check("wd_chctl0", BASE + 3);
        wr(BASE + 3, 8'h01);
        count_high(20, c0, c1);
        check("wd_en_masked", c0, 0);
        rd_check("wd_chctl0_stored", BASE + 3);
        wr(BASE, 8'h83);
        check("wd_clear", fault, 0);
        count_high(10, c0, c1);
        check("wd_pwm_back", c0, 10);
        repeat (89) @(posedge clk);
        #1;
        wr(BASE + 2, 255);
        check("race_no_fault", fault, 0);
        edges_to_fault(n);
        check("race_restart", n, WDOG);
        m_fault = 1'b1;
        for (int i = 0; i < NUM_CH; i++) m_chctl[i][0] = 1'b0;
        wr(BASE, 8'h81);
        rd_check("wd_off_ctrl", BASE);

        wr(BASE + 3, 8'h01);
        wr(BASE + 5, 8'h02);
        bus.port_id = BASE;
        repeat (5) @(posedge clk);
        #1;
        check("ar_pwm_before", pwm_out[0], 1);
        #3 reset = 1'b1;
        #1;
        check("ar_pwm", pwm_out, 0);
        check("ar_dir", dir_out, 0);
        check("ar_rd", bus.read_data, 0);
        #2 reset = 1'b0;
        model_reset();
        for (int i = -1; i <= NREG; i++) rd_check("ar_reg", BASE + 8'(i));
        count_high(20, c0, c1);
        check("ar_pwm_idle", c0 + c1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/motor_pwm_ctrl.md
# motor_pwm_ctrl

Parametrised, KCPSM6-port-mapped motor drive block that replaces single-bit motor/LED control registers with NUM_CH hardware PWM channels. Each channel has glitch-free shadowed duty, enable and direction. A shared programmable prescaler sets the PWM rate, and a communication watchdog forces all motors off if the processor stops writing. It sits on the KCPSM6 port bus beside the UART macros; its read data is merged into the top-level in_port mux.

## Interface
- NUM_CH, 2, number of PWM channels (1..8)
- PWM_BITS, 8, duty resolution (1..8); duty uses the low PWM_BITS bits of out_port
- BASE_ADDR, 8'h10, first port address of the block; the block occupies BASE_ADDR .. BASE_ADDR+1+2*NUM_CH
- WDOG_CYCLES, 10_000_000, watchdog timeout in clk cycles (100 ms at 100 MHz)

Ports:
- clk  in  1  system clock; the single clock domain
- reset  in  1  asynchronous, active-high; all state goes to reset values immediately
- port_id  in  8  KCPSM6 port address
- out_port  in  8  KCPSM6 write data
- write_strobe  in  1  KCPSM6 write qualifier
- read_data  out  8  registered readback for the current port_id
- pwm_out  out  NUM_CH  PWM drive, one bit per channel
- dir_out  out  NUM_CH  direction, one bit per channel
- fault  out  1  sticky watchdog-timeout flag

## Operation
Register map (offset from BASE_ADDR):
- +0 CTRL: bit0 global enable, bit1 watchdog enable. Writing bit7=1 clears fault; bit7 is not stored.
- +1 PRESCALE: PWM tick every PRESCALE+1 clk cycles.
- +2+2i DUTY[i]: written to the channel's pending register.
- +3+2i CHCTL[i]: bit0 enable, bit1 direction.

PWM generation:
- Prescale counter counts 0..PRESCALE and asserts tick on PRESCALE.
- Period counter advances on tick over 0..2^PWM_BITS-2, then wraps to 0.
- pwm_out[i] = enable_all & CHCTL[i].en & ~fault & (period_cnt < active_duty[i]).
- Duty 0 gives 0%. Duty 2^PWM_BITS-1 gives 100% (never low).
- active_duty[i] loads from pending_duty[i] only on the tick where period_cnt wraps to 0, so periods are never truncated.
- dir_out[i] follows CHCTL[i].dir directly. Software is responsible for dead time.

Watchdog:
- Counter runs while CTRL.bit1=1.
- Any write_strobe to an address in the block range clears the counter.
- When the counter reaches WDOG_CYCLES-1, fault sets and all CHCTL enables clear.
- fault stays set until a CTRL write with bit7=1.

Readback, registered on every clk:
- +0 returns {fault, 5'b0, wdog_en, enable_all}.
- +1 returns PRESCALE.
- DUTY[i] returns pending_duty[i].
- CHCTL[i] returns {6'b0, dir, en}.
- Any other address returns 8'h00.

## Timing
- Reset values: CTRL=0, PRESCALE=0, pending/active duty=0, CHCTL=0, prescale/period/watchdog counters=0, pwm_out=0, dir_out=0, fault=0, read_data=0.
- Register write is visible one cycle after the write_strobe cycle.
- pwm_out is registered: one cycle from a counter/duty change to the pin.
- Duty change reaches the output at the next period wrap: latency ≤ (2^PWM_BITS-1)*(PRESCALE+1)+1 cycles.
- PRESCALE write restarts the prescale counter at 0. The period counter is unaffected.
- Simultaneous in-range write and watchdog terminal count: the write wins, counter clears, no fault.
- Simultaneous fault-clear write and terminal count: the clear wins.
- A CHCTL enable write while fault=1 is stored but pwm_out stays 0 until fault clears.
- fault asserts the cycle after terminal count. pwm_out goes low the following cycle.
- Reset asserted mid-period forces pwm_out=0 asynchronously. After reset release, counting restarts from 0.
- read_data updates one cycle after port_id changes; KCPSM6 samples in_port after 2 cycles.

## Structure
- Shared package motor_pwm_pkg holds the register offset constants (CTRL_OFS=0, PRESCALE_OFS=1, CH_BASE_OFS=2) and the CTRL bit indices.
- One sub-module, pwm_channel, instantiated NUM_CH times. It holds pending/active duty, enable, direction and the compare register, and takes the shared period_cnt, wrap, enable_all and fault.
- The top contains address decode, prescaler, period counter, watchdog and the readback mux.

## Test plan
- Duty sweep: PRESCALE=0, CTRL=1, CHCTL0=1, DUTY0=0/64/254/255 → high for 0/64/254/255 of every 255-cycle period; duty 255 never low.
- Shadow load: DUTY0=200 written mid-period at period_cnt=50 → current period keeps the old duty; new duty first seen at period_cnt=0.
- Prescale: PRESCALE=3, DUTY0=10 → pwm_out high 40 cycles per 1020-cycle period.
- Watchdog: WDOG_CYCLES=100 (bench override), CTRL=3, no writes → fault=1 at cycle 100 and pwm_out=0. A CHCTL0 write keeps pwm_out=0. Writing CTRL=8'h83 clears fault.
- Kick race: a write coincides with terminal count → fault stays 0, counter restarts.
- Async reset mid-operation: pwm_out high, reset pulsed between clock edges → outputs 0 without a clock edge. All readbacks return 0 afterwards.
